dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the LC-3b datapath's data-memory port. It services the `mem_read` and `mem_write` requests raised by the decoded control word. It holds a word-organised, byte-writable storage array and answers each request after a fixed, parameterised latency with a single-cycle `mem_resp`. It sits between the MEM stage and the storage model, and provides the stall/response handshake the pipeline waits on.

## Interface
- `ADDR_BITS`, default 8: log2 of the word count; the array holds 2^ADDR_BITS 16-bit words.
- `LATENCY`, default 2: cycles from request acceptance to `mem_resp`; legal range 1..15.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `mem_read` input 1: read request; held by the initiator until `mem_resp`.
- `mem_write` input 1: write request; held by the initiator until `mem_resp`.
- `mem_address` input 16: byte address; bit 0 is ignored for word selection.
- `mem_wdata` input 16: write data.
- `mem_byte_enable` input 2: bit 0 enables `wdata[7:0]`; bit 1 enables `wdata[15:8]`.
- `mem_rdata` output 16: read data, valid only while `mem_resp`=1.
- `mem_resp` output 1: one-cycle completion pulse.
- `busy` output 1: high from the cycle after acceptance through the `mem_resp` cycle.

## Operation
- FSM states:
  - **IDLE**: accepts a request.
  - **WAIT**: counting latency.
  - **RESP**: responding.
- **IDLE**
  - If `mem_write` or `mem_read` is high at a rising edge, capture the following into internal registers and load `cnt` = `LATENCY`-1:
    - op (write has priority when both are high; the read is dropped and no second response is given)
    - word index = `mem_address[ADDR_BITS:1]`
    - `wdata`
    - `byte_enable`
  - If `cnt`=0 after load (`LATENCY`=1), go to RESP; otherwise go to WAIT.
- **WAIT**
  - Decrement `cnt` each cycle.
  - When `cnt` reaches 0, go to RESP.
  - Input changes during WAIT are ignored; the captured values are used.
- **Commit on the edge entering RESP**
  - Write: update only the enabled byte lanes of the addressed word. `byte_enable`=00 modifies nothing but still responds.
  - Read: register the full addressed word into `mem_rdata`. `byte_enable` is ignored for reads.
  - A read issued after a completed write to the same word returns the new data.
- **RESP**
  - `mem_resp`=1 for exactly one cycle, then go to IDLE.
  - A request still asserted in the cycle after RESP is treated as a new request.
- **Address aliasing**: `mem_address` bits above `ADDR_BITS` are ignored, so addresses wrap modulo 2^(`ADDR_BITS`+1) bytes.
- **Reset** (asynchronous, any state):
  - FSM goes to IDLE and `cnt`=0.
  - `mem_resp`=0, `busy`=0, `mem_rdata`=0x0000.
  - Every array word is cleared to 0x0000.
  - An in-flight transaction is abandoned: no response is given, and an uncommitted write never reaches the array.

## Timing
- Request high at edge T (IDLE) → `mem_resp` high during cycle T+`LATENCY`, low at T+`LATENCY`+1.
- Fastest back-to-back throughput: one transaction per `LATENCY`+1 cycles.
- `busy` is high in cycles T+1 .. T+`LATENCY`, i.e. it covers RESP and spans `LATENCY` cycles.
- `mem_rdata` is stable only during the RESP cycle. It holds its last value afterward, but the initiator must not rely on that.
- Reset deassertion: the first request may be accepted on the first rising edge after `rst_n` goes high.

## Test plan
- **Reset**: `rst_n`=0 → `mem_resp`=0, `busy`=0, `mem_rdata`=0x0000. After release, a read of byte address 0x0010 → 0x0000.
- **Latency**: with `LATENCY`=2, write 0xBEEF to 0x0020 (`be`=11) accepted at T → `mem_resp` only at T+2. A read of 0x0020 accepted at T+3 → `mem_resp` at T+5 with `mem_rdata`=0xBEEF.
- **Byte lanes**: preload 0x1234 at 0x0040. Write 0xAB00 with `be`=10, then read → 0xAB34. Write 0x00CD with `be`=01, then read → 0xABCD. Write with `be`=00, then read → 0xABCD.
- **Priority and aliasing**: `mem_read`=`mem_write`=1, `wdata`=0x5555, address 0x0002 → exactly one `mem_resp`, and a later read returns 0x5555. With `ADDR_BITS`=8, a read of 0x0202 also returns 0x5555.
- **Reset mid-transaction**: write 0x7777 to 0x0060, assert `rst_n`=0 during WAIT, release → no `mem_resp` is ever seen for that write. A read of 0x0060 → 0x0000.
- **Hold and ignore**: change `mem_address` and `wdata` during WAIT → the captured values are committed. With `LATENCY`=1, each request still held after RESP completes every 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-writable word array that answers each read or
// write request with a one-cycle mem_resp a fixed LATENCY cycles after acceptance.
module dmem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    input  logic [1:0]  mem_byte_enable,
    output logic [15:0] mem_rdata,
    output logic        mem_resp,
    output logic        busy,
    output logic [1:0]  o_dbg_state
);

    // Handshake: the initiator holds mem_read/mem_write (and its operands)
    // until mem_resp; a request is accepted only in IDLE, and mem_resp is a
    // single-cycle pulse during which mem_rdata is valid.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int         WORDS    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [3:0]             r_cnt;
    logic                   r_op_write;
    logic [ADDR_BITS-1:0]   r_idx;
    logic [15:0]            r_wdata;
    logic [1:0]             r_be;
    logic [15:0]            r_rdata;
    logic [15:0]            r_mem [WORDS];

    logic                   w_accept;
    logic                   w_enter_resp;
    logic                   w_op_write;
    logic [ADDR_BITS-1:0]   w_idx;
    logic [15:0]            w_wdata;
    logic [1:0]             w_be;
    logic                   w_unused_addr;

    assign w_accept      = (r_state == S_IDLE) && (mem_read || mem_write);
    assign w_enter_resp  = (w_next == S_RESP) && (r_state != S_RESP);
    assign w_unused_addr = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

    // With LATENCY=1 the commit happens on the accepting edge, before the
    // capture registers hold anything, so the live inputs are used then.
    assign w_op_write = w_accept ? mem_write                      : r_op_write;
    assign w_idx      = w_accept ? mem_address[ADDR_BITS:1]       : r_idx;
    assign w_wdata    = w_accept ? mem_wdata                      : r_wdata;
    assign w_be       = w_accept ? mem_byte_enable                : r_be;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (CNT_LOAD == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_resp    = (r_state == S_RESP);
        busy        = (r_state != S_IDLE);
        mem_rdata   = r_rdata;
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 4'd0;
            r_op_write <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 16'h0000;
            r_be       <= 2'b00;
        end else if (w_accept) begin
            r_cnt      <= CNT_LOAD;
            r_op_write <= mem_write;
            r_idx      <= mem_address[ADDR_BITS:1];
            r_wdata    <= mem_wdata;
            r_be       <= mem_byte_enable;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Array and read data commit only on the edge entering RESP, so a reset
    // during WAIT discards the pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) begin
                r_mem[i] <= 16'h0000;
            end
        end else if (w_enter_resp && w_op_write) begin
            if (w_be[0]) r_mem[w_idx][7:0]  <= w_wdata[7:0];
            if (w_be[1]) r_mem[w_idx][15:8] <= w_wdata[15:8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 16'h0000;
        end else if (w_enter_resp && !w_op_write) begin
            r_rdata <= r_mem[w_idx];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed and random transactions against a
// word-array reference model, plus a LATENCY=1 instance for throughput.
module tb_dmem_responder;

    localparam int A_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_rd, a_wr, a_resp, a_busy;
    logic [15:0] a_addr, a_wdata, a_rdata;
    logic [1:0]  a_be, a_dbg;

    logic        b_rd, b_wr, b_resp, b_busy;
    logic [15:0] b_addr, b_wdata, b_rdata;
    logic [1:0]  b_be, b_dbg;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model [256];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_BITS(8), .LATENCY(A_LAT)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .mem_read(a_rd), .mem_write(a_wr), .mem_address(a_addr),
        .mem_wdata(a_wdata), .mem_byte_enable(a_be),
        .mem_rdata(a_rdata), .mem_resp(a_resp), .busy(a_busy),
        .o_dbg_state(a_dbg)
    );

    dmem_responder #(.ADDR_BITS(8), .LATENCY(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .mem_read(b_rd), .mem_write(b_wr), .mem_address(b_addr),
        .mem_wdata(b_wdata), .mem_byte_enable(b_be),
        .mem_rdata(b_rdata), .mem_resp(b_resp), .busy(b_busy),
        .o_dbg_state(b_dbg)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [15:0] addr);
        return int'((addr >> 1) & 16'h00ff);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;
    endtask

    // One complete transaction on instance A, checked against the model.
    task automatic txn(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [1:0] be,
                       input bit scramble, input string tag);
        logic [15:0] exp;
        int          n;
        exp = model[widx(addr)];
        if (wr) begin
            if (be[0]) model[widx(addr)][7:0]  = wdata[7:0];
            if (be[1]) model[widx(addr)][15:8] = wdata[15:8];
        end
        @(negedge clk);
        a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata; a_be = be;
        @(posedge clk); #1;
        check($sformatf("%s_busy_accept", tag), {15'd0, a_busy}, 16'd1);
        if (scramble) begin
            a_addr  = 16'($urandom);
            a_wdata = 16'($urandom);
            a_be    = 2'($urandom);
        end
        n = 0;
        while (a_resp !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("%s_latency", tag), 16'(n), 16'(A_LAT - 1));
        if (!wr) check($sformatf("%s_rdata", tag), a_rdata, exp);
        check($sformatf("%s_busy_resp", tag), {15'd0, a_busy}, 16'd1);
        a_rd = 1'b0; a_wr = 1'b0;
        @(posedge clk); #1;
        check($sformatf("%s_resp_done", tag), {15'd0, a_resp}, 16'd0);
        check($sformatf("%s_busy_done", tag), {15'd0, a_busy}, 16'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          seen;
        logic        rd, wr;
        logic [15:0] addr;

        rst_n = 1'b0;
        a_rd = 0; a_wr = 0; a_addr = 0; a_wdata = 0; a_be = 0;
        b_rd = 0; b_wr = 0; b_addr = 0; b_wdata = 0; b_be = 0;
        clear_model();
        repeat (3) @(negedge clk);
        check("reset_a_resp",  {15'd0, a_resp}, 16'd0);
        check("reset_a_busy",  {15'd0, a_busy}, 16'd0);
        check("reset_a_rdata", a_rdata, 16'h0000);
        check("reset_b_resp",  {15'd0, b_resp}, 16'd0);
        check("reset_b_rdata", b_rdata, 16'h0000);
        rst_n = 1'b1;

        txn(1, 0, 16'h0010, 16'h0000, 2'b11, 0, "rd_after_reset");
        txn(0, 1, 16'h0020, 16'hBEEF, 2'b11, 0, "wr_beef");
        txn(1, 0, 16'h0020, 16'h0000, 2'b00, 0, "rd_beef");
        check("rd_beef_const", a_rdata, 16'hBEEF);

        txn(0, 1, 16'h0040, 16'h1234, 2'b11, 0, "preload");
        txn(0, 1, 16'h0040, 16'hAB00, 2'b10, 0, "wr_hi");
        txn(1, 0, 16'h0040, 16'h0000, 2'b00, 0, "rd_hi");
        check("rd_hi_const", a_rdata, 16'hAB34);
        txn(0, 1, 16'h0040, 16'h00CD, 2'b01, 0, "wr_lo");
        txn(1, 0, 16'h0040, 16'h0000, 2'b11, 0, "rd_lo");
        check("rd_lo_const", a_rdata, 16'hABCD);
        txn(0, 1, 16'h0040, 16'hFFFF, 2'b00, 0, "wr_none");
        txn(1, 0, 16'h0040, 16'h0000, 2'b11, 0, "rd_none");
        check("rd_none_const", a_rdata, 16'hABCD);

        txn(1, 1, 16'h0002, 16'h5555, 2'b11, 0, "both_high");
        txn(1, 0, 16'h0002, 16'h0000, 2'b11, 0, "rd_prio");
        txn(1, 0, 16'h0202, 16'h0000, 2'b11, 0, "rd_alias");
        check("rd_alias_const", a_rdata, 16'h5555);

        txn(0, 1, 16'h0070, 16'h9A9A, 2'b11, 1, "wr_scramble");
        txn(1, 0, 16'h0071, 16'h0000, 2'b11, 1, "rd_scramble");

        // Reset while the write to 0x0060 is still in WAIT.
        @(negedge clk);
        a_wr = 1; a_addr = 16'h0060; a_wdata = 16'h7777; a_be = 2'b11;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_resp",  {15'd0, a_resp}, 16'd0);
        check("midrst_busy",  {15'd0, a_busy}, 16'd0);
        check("midrst_rdata", a_rdata, 16'h0000);
        clear_model();
        a_wr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (a_resp === 1'b1) seen++;
        end
        check("midrst_no_resp", 16'(seen), 16'd0);
        txn(1, 0, 16'h0060, 16'h0000, 2'b11, 0, "rd_after_midrst");
        txn(1, 0, 16'h0070, 16'h0000, 2'b11, 0, "rd_cleared");

        for (int i = 0; i < 40; i++) begin
            wr   = 1'($urandom_range(0, 1));
            rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            addr = 16'(($urandom_range(0, 255) << 9) | ($urandom_range(0, 7) << 1)
                        | $urandom_range(0, 1));
            txn(rd, wr, addr, 16'($urandom), 2'($urandom_range(0, 3)), 0,
                $sformatf("rand%0d", i));
        end

        // LATENCY=1 instance with a read held continuously: one response
        // every two cycles.
        @(negedge clk);
        b_rd = 1'b1; b_addr = 16'h0010;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("b_hold_resp%0d", k), {15'd0, b_resp}, 16'((k % 2) == 0));
            check($sformatf("b_hold_busy%0d", k), {15'd0, b_busy}, 16'((k % 2) == 0));
            if (k % 2 == 0) check($sformatf("b_hold_rdata%0d", k), b_rdata, 16'h0000);
        end
        b_rd = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
